// File: rtl/led_pkg.sv
// Shared mode encoding and helpers for the LED pattern generator.
// Breathe mode is only honoured when LED_BREATHE_EN is defined.
package led_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 3'b000,
        MODE_ON      = 3'b001,
        MODE_BLINK   = 3'b010,
        MODE_PWM     = 3'b011,
        MODE_BREATHE = 3'b100
    } mode_e;

    // Unknown codes (and breathe when it is not built) collapse to off.
    function automatic mode_e sanitize_mode(input logic [MODE_W-1:0] mode,
                                            input bit breathe_ok);
        case (mode)
            MODE_ON:      return MODE_ON;
            MODE_BLINK:   return MODE_BLINK;
            MODE_PWM:     return MODE_PWM;
            MODE_BREATHE: return breathe_ok ? MODE_BREATHE : MODE_OFF;
            default:      return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: shadow/active configuration and lit decision.
// Breathe level/direction exist only when LED_BREATHE_EN is defined.
module led_channel
    import led_pkg::*;
#(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              apply,
    input  logic              we,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [DUTY_W-1:0] wr_duty,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic              blink_phase,
    output logic              lit
);

`ifdef LED_BREATHE_EN
    localparam bit BREATHE_OK = 1'b1;
`else
    localparam bit BREATHE_OK = 1'b0;
`endif

    mode_e             shadow_mode;
    mode_e             active_mode;
    logic [DUTY_W-1:0] shadow_duty;
    logic [DUTY_W-1:0] active_duty;

    // A write coinciding with apply lands in shadow only; active takes the old shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_mode <= MODE_OFF;
            shadow_duty <= '0;
            active_mode <= MODE_OFF;
            active_duty <= '0;
        end else begin
            if (apply) begin
                active_mode <= shadow_mode;
                active_duty <= shadow_duty;
            end
            if (we) begin
                shadow_mode <= sanitize_mode(wr_mode, BREATHE_OK);
                shadow_duty <= wr_duty;
            end
        end
    end

`ifdef LED_BREATHE_EN
    localparam logic [DUTY_W-1:0] LEVEL_MAX = '1;

    logic              pending;
    logic [DUTY_W-1:0] level;
    logic              level_down;

    // A freshly applied write restarts the ramp; otherwise step once per tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 1'b0;
            level      <= '0;
            level_down <= 1'b0;
        end else if (apply) begin
            pending <= we;
            if (pending) begin
                level      <= '0;
                level_down <= 1'b0;
            end else if (active_mode == MODE_BREATHE) begin
                if (!level_down) begin
                    if (level == LEVEL_MAX) begin
                        level      <= LEVEL_MAX - DUTY_W'(1);
                        level_down <= 1'b1;
                    end else begin
                        level <= level + DUTY_W'(1);
                    end
                end else begin
                    if (level == '0) begin
                        level      <= DUTY_W'(1);
                        level_down <= 1'b0;
                    end else begin
                        level <= level - DUTY_W'(1);
                    end
                end
            end
        end else if (we) begin
            pending <= 1'b1;
        end
    end
`endif

    always_comb begin
        lit = 1'b0;
        case (active_mode)
            MODE_ON:      lit = 1'b1;
            MODE_BLINK:   lit = blink_phase;
            MODE_PWM:     lit = (pwm_cnt < active_duty);
`ifdef LED_BREATHE_EN
            MODE_BREATHE: lit = (pwm_cnt < level);
`endif
            default:      lit = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: period/PWM counters, config port and output register.
// Define LED_BREATHE_EN to enable breathe mode (3'b100) in every channel.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int PERIOD     = 1_000_000,
    parameter int CNT_W      = 32,
    parameter int DUTY_W     = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             enable,
    input  logic                                             cfg_we,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] cfg_ch,
    input  logic [MODE_W-1:0]                                cfg_mode,
    input  logic [DUTY_W-1:0]                                cfg_duty,
    output logic                                             cfg_ack,
    output logic                                             cfg_err,
    output logic                                             tick,
    output logic [NUM_LEDS-1:0]                              led
);

    localparam int                 CH_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [NUM_LEDS-1:0] UNLIT = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]    cnt;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic                blink_phase;
    logic                wrap;
    logic                cfg_valid;
    logic [NUM_LEDS-1:0] lit;

    assign wrap      = enable && (cnt == CNT_W'(PERIOD - 1));
    assign cfg_valid = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_LEDS));

    // Counters only advance while enabled so a pause resumes exactly where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            pwm_cnt     <= '0;
            blink_phase <= 1'b0;
            tick        <= 1'b0;
        end else begin
            tick <= wrap;
            if (enable) begin
                cnt     <= wrap ? '0 : cnt + CNT_W'(1);
                pwm_cnt <= pwm_cnt + DUTY_W'(1);
                if (wrap) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_we;
            cfg_err <= cfg_we && !cfg_valid;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_channel #(
            .DUTY_W(DUTY_W)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .apply      (wrap),
            .we         (cfg_we && cfg_valid && (cfg_ch == CH_W'(i))),
            .wr_mode    (cfg_mode),
            .wr_duty    (cfg_duty),
            .pwm_cnt    (pwm_cnt),
            .blink_phase(blink_phase),
            .lit        (lit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            led <= UNLIT;
        end else begin
            led <= lit ^ UNLIT;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a counting reference model.
// Expectations for mode 3'b100 follow LED_BREATHE_EN.
module tb_led_pattern_gen;

    localparam int NUM_LEDS = 4;
    localparam int PERIOD   = 10;
    localparam int CNT_W    = 8;
    localparam int DUTY_W   = 4;
    localparam int FRAME    = 1 << DUTY_W;
    localparam int LMAX     = FRAME - 1;

    logic                clk = 1'b0;
    logic                reset, enable, cfg_we;
    logic [1:0]          cfg_ch;
    logic [2:0]          cfg_mode;
    logic [DUTY_W-1:0]   cfg_duty;
    logic                cfg_ack, cfg_err, tick;
    logic [NUM_LEDS-1:0] led;

    logic                cfg_we5;
    logic [2:0]          cfg_ch5;
    logic [2:0]          cfg_mode5;
    logic                cfg_ack5, cfg_err5, tick5;
    logic [4:0]          led5;

    int checks = 0;
    int errors = 0;

    // Reference model: everything derives from the count of enabled clocks since reset.
    int unsigned en_clks;
    logic [2:0]        sh_mode [NUM_LEDS];
    logic [DUTY_W-1:0] sh_duty [NUM_LEDS];
    logic [2:0]        ac_mode [NUM_LEDS];
    logic [DUTY_W-1:0] ac_duty [NUM_LEDS];
    bit                pend    [NUM_LEDS];
    int unsigned       start_tick [NUM_LEDS];
    logic [NUM_LEDS-1:0] exp_led;
    logic exp_tick, exp_ack, exp_err;

    led_pattern_gen #(
        .NUM_LEDS(NUM_LEDS), .PERIOD(PERIOD), .CNT_W(CNT_W), .DUTY_W(DUTY_W), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .tick(tick), .led(led)
    );

    led_pattern_gen #(
        .NUM_LEDS(5), .PERIOD(PERIOD), .CNT_W(CNT_W), .DUTY_W(DUTY_W), .ACTIVE_LOW(1)
    ) dut5 (
        .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we5), .cfg_ch(cfg_ch5),
        .cfg_mode(cfg_mode5), .cfg_duty(4'd0), .cfg_ack(cfg_ack5), .cfg_err(cfg_err5),
        .tick(tick5), .led(led5)
    );

    always #5 clk = ~clk;

    function automatic int unsigned tri_level(int unsigned k);
        int unsigned m;
        m = k % (2 * LMAX);
        return (m <= LMAX) ? m : (2 * LMAX) - m;
    endfunction

    function automatic bit model_lit(int i);
        int unsigned pwm;
        bit phase;
        pwm   = en_clks % FRAME;
        phase = ((en_clks / PERIOD) % 2) == 1;
        case (ac_mode[i])
            3'd1: return 1'b1;
            3'd2: return phase;
            3'd3: return pwm < ac_duty[i];
`ifdef LED_BREATHE_EN
            3'd4: return pwm < tri_level(en_clks / PERIOD - start_tick[i]);
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_step();
        logic [NUM_LEDS-1:0] lit;
        bit wrap;
        if (reset) begin
            en_clks = 0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                sh_mode[i] = 0; sh_duty[i] = 0; ac_mode[i] = 0; ac_duty[i] = 0;
                pend[i] = 0; start_tick[i] = 0;
            end
            exp_led = '1; exp_tick = 0; exp_ack = 0; exp_err = 0;
            return;
        end
        for (int i = 0; i < NUM_LEDS; i++) lit[i] = model_lit(i);
        exp_led  = enable ? ~lit : '1;
        wrap     = enable && (en_clks % PERIOD == PERIOD - 1);
        exp_tick = wrap;
        if (wrap) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                ac_mode[i] = sh_mode[i];
                ac_duty[i] = sh_duty[i];
                if (pend[i]) start_tick[i] = en_clks / PERIOD + 1;
                pend[i] = 0;
            end
        end
        exp_ack = cfg_we;
        exp_err = cfg_we && (int'(cfg_ch) >= NUM_LEDS);
        if (cfg_we && int'(cfg_ch) < NUM_LEDS) begin
            sh_mode[cfg_ch] = cfg_mode;
            sh_duty[cfg_ch] = cfg_duty;
            pend[cfg_ch]    = 1;
        end
        if (enable) en_clks++;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [2:0] mode, input logic [DUTY_W-1:0] duty);
        cfg_we = 1; cfg_ch = ch; cfg_mode = mode; cfg_duty = duty;
        clk_step();
        cfg_we = 0;
        checks++;
        if (cfg_ack !== exp_ack) begin
            errors++; $display("[TB] FAIL write_ack ch%0d: got %b expected %b", ch, cfg_ack, exp_ack);
        end
        checks++;
        if (cfg_err !== exp_err) begin
            errors++; $display("[TB] FAIL write_err ch%0d: got %b expected %b", ch, cfg_err, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; cfg_we = 0; cfg_ch = 0; cfg_mode = 0; cfg_duty = 0;
        cfg_we5 = 0; cfg_ch5 = 0; cfg_mode5 = 0;
        clk_step();
        clk_step();
        checks++;
        if (led !== exp_led) begin errors++; $display("[TB] FAIL reset_led: got %b expected %b", led, exp_led); end
        checks++;
        if ({tick, cfg_ack, cfg_err} !== {exp_tick, exp_ack, exp_err}) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected %b", {tick, cfg_ack, cfg_err}, {exp_tick, exp_ack, exp_err});
        end
        reset = 0;
    endtask

    task automatic test_idle();
        int nticks = 0;
        enable = 1;
        for (int k = 1; k <= 40; k++) begin
            clk_step();
            if (tick === 1'b1) nticks++;
            checks++;
            if (led !== exp_led) begin errors++; $display("[TB] FAIL idle_led clk %0d: got %b expected %b", k, led, exp_led); end
            checks++;
            if (tick !== exp_tick) begin errors++; $display("[TB] FAIL idle_tick clk %0d: got %b expected %b", k, tick, exp_tick); end
        end
        checks++;
        if (nticks != 4) begin errors++; $display("[TB] FAIL idle_tick_count: got %0d expected 4", nticks); end
    endtask

    task automatic test_blink();
        int lows = 0;
        applyStimulus(2'd0, 3'b010, 4'd0);
        for (int k = 0; k < 32; k++) begin
            clk_step();
            if (k >= 12 && led[0] === 1'b0) lows++;
            checks++;
            if (led !== exp_led) begin errors++; $display("[TB] FAIL blink_led step %0d: got %b expected %b", k, led, exp_led); end
            checks++;
            if (tick !== exp_tick) begin errors++; $display("[TB] FAIL blink_tick step %0d: got %b expected %b", k, tick, exp_tick); end
        end
        checks++;
        if (lows != 10) begin errors++; $display("[TB] FAIL blink_duty: got %0d lit clocks expected 10", lows); end
    endtask

    task automatic test_pwm();
        int lows;
        for (int pass = 0; pass < 2; pass++) begin
            lows = 0;
            applyStimulus(2'd2, 3'b011, (pass == 0) ? 4'd4 : 4'd0);
            for (int k = 0; k < 28; k++) begin
                clk_step();
                if (k >= 12 && led[2] === 1'b0) lows++;
                checks++;
                if (led !== exp_led) begin errors++; $display("[TB] FAIL pwm_led step %0d: got %b expected %b", k, led, exp_led); end
            end
            checks++;
            if (lows != ((pass == 0) ? 4 : 0)) begin
                errors++; $display("[TB] FAIL pwm_frame pass %0d: got %0d lit clocks expected %0d", pass, lows, (pass == 0) ? 4 : 0);
            end
        end
    endtask

    task automatic test_config_err();
        int waited = 0;
        for (int c = 5; c <= 7; c++) begin
            cfg_we5 = 1; cfg_ch5 = 3'(c); cfg_mode5 = 3'b001;
            clk_step();
            cfg_we5 = 0;
            checks++;
            if ({cfg_ack5, cfg_err5} !== 2'b11) begin errors++; $display("[TB] FAIL bad_ch%0d_ack_err: got %b expected 11", c, {cfg_ack5, cfg_err5}); end
        end
        cfg_we5 = 1; cfg_ch5 = 3'd4; cfg_mode5 = 3'b001;
        clk_step();
        cfg_we5 = 0;
        checks++;
        if ({cfg_ack5, cfg_err5} !== 2'b10) begin errors++; $display("[TB] FAIL good_ch4_ack_err: got %b expected 10", {cfg_ack5, cfg_err5}); end
        checks++;
        if (led5 !== 5'b11111) begin errors++; $display("[TB] FAIL bad_ch_led_unchanged: got %b expected 11111", led5); end
        while (led5[4] !== 1'b0 && waited < 30) begin
            clk_step();
            waited++;
            checks++;
            if (tick5 !== exp_tick) begin errors++; $display("[TB] FAIL dut5_tick: got %b expected %b", tick5, exp_tick); end
        end
        checks++;
        if (led5 !== 5'b01111) begin errors++; $display("[TB] FAIL dut5_ch4_on after %0d clocks: got %b expected 01111", waited, led5); end

        applyStimulus(2'd1, 3'b001, 4'd3);
        applyStimulus(2'd1, 3'b000, 4'd0);
        for (int k = 0; k < 24; k++) begin
            clk_step();
            checks++;
            if (led !== exp_led) begin errors++; $display("[TB] FAIL last_wins_led step %0d: got %b expected %b", k, led, exp_led); end
        end
        checks++;
        if (led[1] !== 1'b1) begin errors++; $display("[TB] FAIL last_wins_ch1: got %b expected 1", led[1]); end
    endtask

    task automatic test_pause();
        applyStimulus(2'd3, 3'b001, 4'd0);
        for (int k = 0; k < 12; k++) clk_step();
        checks++;
        if (led[3] !== 1'b0) begin errors++; $display("[TB] FAIL pause_ch3_on: got %b expected 0", led[3]); end
        for (int k = 0; k < 37; k++) begin
            enable = (k < 3 || k >= 10);
            clk_step();
            checks++;
            if (led !== exp_led) begin errors++; $display("[TB] FAIL pause_led step %0d: got %b expected %b", k, led, exp_led); end
            checks++;
            if (tick !== exp_tick) begin errors++; $display("[TB] FAIL pause_tick step %0d: got %b expected %b", k, tick, exp_tick); end
        end
        enable = 1;
    endtask

    task automatic test_breathe();
        applyStimulus(2'd0, 3'b100, 4'd0);
        for (int k = 0; k < 200; k++) begin
            clk_step();
            checks++;
            if (led !== exp_led) begin errors++; $display("[TB] FAIL breathe_led step %0d: got %b expected %b", k, led, exp_led); end
        end
        reset = 1;
        clk_step();
        reset = 0;
        checks++;
        if (led !== 4'b1111) begin errors++; $display("[TB] FAIL breathe_reset_led: got %b expected 1111", led); end
        for (int k = 0; k < 30; k++) begin
            clk_step();
            checks++;
            if (led !== exp_led) begin errors++; $display("[TB] FAIL post_reset_led step %0d: got %b expected %b", k, led, exp_led); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            reset    = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            cfg_we   = ($urandom_range(0, 4) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_mode = 3'($urandom_range(0, 7));
            cfg_duty = 4'($urandom_range(0, 15));
            clk_step();
            checks++;
            if (led !== exp_led) begin errors++; $display("[TB] FAIL rand_led step %0d: got %b expected %b", k, led, exp_led); end
            checks++;
            if ({tick, cfg_ack, cfg_err} !== {exp_tick, exp_ack, exp_err}) begin
                errors++; $display("[TB] FAIL rand_flags step %0d: got %b expected %b", k, {tick, cfg_ack, cfg_err}, {exp_tick, exp_ack, exp_err});
            end
        end
        reset = 0; cfg_we = 0; enable = 1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_blink();
        test_pwm();
        test_config_err();
        test_pause();
        test_breathe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
